// File: rtl/mirrored_bus_ram.sv
// Synchronous RAM slave for the 2A03 CPU bus: window decode with mirroring, post-reset fill sweep.
// Optional write protect (wp / wp_violation) is compiled in when MIRRORED_BUS_RAM_WP_EN is defined.

module mirrored_bus_ram #(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 8,
  parameter int                DEPTH_LOG2     = 11,
  parameter logic [ADDR_W-1:0] BASE           = '0,
  parameter int                WINDOW_LOG2    = 13,
  parameter int                READ_LATENCY   = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE     = '0
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              sel,
  output logic              ready
`ifdef MIRRORED_BUS_RAM_WP_EN
  ,
  input  logic              wp,
  output logic              wp_violation
`endif
);

  localparam int                 WORDS = 1 << DEPTH_LOG2;
  localparam int                 CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [DEPTH_LOG2-1:0]  index;
  logic                   run, rd_hit, wr_hit, wp_block;
  logic                   mem_we;
  logic [DEPTH_LOG2-1:0]  mem_waddr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      s1_data_reg;
  logic                   s1_oe_reg;
  logic                   unused_addr;

  logic [DATA_W-1:0] mem [WORDS];

  assign sel         = (addr >> WINDOW_LOG2) == (BASE >> WINDOW_LOG2);
  // Low address bits only: the array repeats across the whole decode window.
  assign index       = addr[DEPTH_LOG2-1:0];
  assign unused_addr = ^addr;
  assign run         = (state_reg == ST_RUN);
  assign ready       = run;

`ifdef MIRRORED_BUS_RAM_WP_EN
  assign wp_block = wp;
`else
  assign wp_block = 1'b0;
`endif

  assign rd_hit = run & sel & rw;
  assign wr_hit = run & sel & ~rw & ~wp_block;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_reg <= RESET_STATE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    mem_we     = 1'b0;
    mem_waddr  = index;
    mem_wdata  = data_in;
    case (state_reg)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = count_reg[DEPTH_LOG2-1:0];
        mem_wdata  = FILL_VALUE;
        count_next = count_reg + 1'b1;
        if (count_reg == LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we = wr_hit;
      end
    endcase
  end

  // Array write port has no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s1_data_reg <= '0;
      s1_oe_reg   <= 1'b0;
    end else begin
      s1_data_reg <= rd_hit ? mem[index] : '0;
      s1_oe_reg   <= rd_hit;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] s2_data_reg;
      logic              s2_oe_reg;
      always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
          s2_data_reg <= '0;
          s2_oe_reg   <= 1'b0;
        end else begin
          s2_data_reg <= s1_data_reg;
          s2_oe_reg   <= s1_oe_reg;
        end
      end
      assign data_out = s2_data_reg;
      assign data_oe  = s2_oe_reg;
    end else begin : g_lat1
      assign data_out = s1_data_reg;
      assign data_oe  = s1_oe_reg;
    end
  endgenerate

`ifdef MIRRORED_BUS_RAM_WP_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wp_violation <= 1'b0;
    end else if (run & sel & ~rw & wp) begin
      wp_violation <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mirrored_bus_ram.sv
// Bench for mirrored_bus_ram: a latency-1 instance (fill $00) and a latency-2 instance (fill $C3)
// share one bus and are compared against a window/mirror model built from plain arithmetic.

module tb_mirrored_bus_ram;

  logic        clock   = 1'b0;
  logic        nreset  = 1'b0;
  logic [15:0] addr    = 16'h0000;
  logic        rw      = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  d1_out, d2_out;
  logic        d1_oe, d2_oe, d1_sel, d2_sel, d1_ready, d2_ready;
`ifdef MIRRORED_BUS_RAM_WP_EN
  logic        wp = 1'b0;
  logic        wpv1, wpv2;
`endif

  always #5 clock = ~clock;

  mirrored_bus_ram #(.READ_LATENCY(1), .FILL_VALUE(8'h00)) dut1 (
    .clock(clock), .nreset(nreset), .addr(addr), .rw(rw), .data_in(data_in),
    .data_out(d1_out), .data_oe(d1_oe), .sel(d1_sel), .ready(d1_ready)
`ifdef MIRRORED_BUS_RAM_WP_EN
    , .wp(wp), .wp_violation(wpv1)
`endif
  );

  mirrored_bus_ram #(.READ_LATENCY(2), .FILL_VALUE(8'hC3)) dut2 (
    .clock(clock), .nreset(nreset), .addr(addr), .rw(rw), .data_in(data_in),
    .data_out(d2_out), .data_oe(d2_oe), .sel(d2_sel), .ready(d2_ready)
`ifdef MIRRORED_BUS_RAM_WP_EN
    , .wp(wp), .wp_violation(wpv2)
`endif
  );

  localparam logic [7:0] FILL1 = 8'h00;
  localparam logic [7:0] FILL2 = 8'hC3;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] m1 [2048];
  logic [7:0] m2 [2048];
  bit         in_run = 1'b0;
  logic [7:0] e1_data = 8'h00, p2_data = 8'h00, e2_data = 8'h00;
  logic       e1_oe = 1'b0, p2_oe = 1'b0, e2_oe = 1'b0;

  // Drive one bus cycle at the falling edge, predict both outputs, return at the next falling edge.
  task automatic do_cycle(input logic [15:0] a, input logic r, input logic [7:0] d);
    int idx;
    bit hit;
    bit blocked;
    addr = a; rw = r; data_in = d;
    idx = int'(a) % 2048;
    hit = in_run && (a < 16'h2000);
    blocked = 1'b0;
`ifdef MIRRORED_BUS_RAM_WP_EN
    blocked = wp;
`endif
    e2_data = p2_data; e2_oe = p2_oe;
    e1_oe   = hit && r;
    p2_oe   = e1_oe;
    e1_data = e1_oe ? m1[idx] : 8'h00;
    p2_data = e1_oe ? m2[idx] : 8'h00;
    if (hit && !r && !blocked) begin
      m1[idx] = d;
      m2[idx] = d;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    in_run = 1'b0;
    e1_data = 8'h00; p2_data = 8'h00; e2_data = 8'h00;
    e1_oe = 1'b0; p2_oe = 1'b0; e2_oe = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      m1[i] = FILL1;
      m2[i] = FILL2;
    end
  endtask

  task automatic test_reset();
    int early;
    bit bad_out;
    apply_reset();
    addr = 16'h2000; rw = 1'b1;
    #1;
    n_checks++;
    if ({d1_ready, d2_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {d1_ready, d2_ready});
    else n_pass++;
    n_checks++;
    if ({d1_oe, d2_oe, d1_out, d2_out} !== 18'h0) $display("FAIL reset_outputs: got %h expected 0", {d1_oe, d2_oe, d1_out, d2_out});
    else n_pass++;
    n_checks++;
    if (d1_sel !== 1'b0) $display("FAIL reset_sel_2000: got %b expected 0", d1_sel);
    else n_pass++;
    addr = 16'h1FFF;
    #1;
    n_checks++;
    if (d1_sel !== 1'b1) $display("FAIL reset_sel_1fff: got %b expected 1", d1_sel);
    else n_pass++;
`ifdef MIRRORED_BUS_RAM_WP_EN
    n_checks++;
    if (wpv1 !== 1'b0) $display("FAIL reset_wp_violation: got %b expected 0", wpv1);
    else n_pass++;
`endif
    @(negedge clock);
    nreset = 1'b1;
    early = -1; bad_out = 1'b0;
    for (int i = 1; i <= 2048; i++) begin
      do_cycle(16'($urandom_range(0, 16'h1FFF)), 1'($urandom_range(0, 1)), 8'($urandom));
      if (i < 2048 && {d1_ready, d2_ready} !== 2'b00 && early < 0) early = i;
      if ({d1_oe, d2_oe, d1_out, d2_out} !== 18'h0) bad_out = 1'b1;
    end
    n_checks++;
    if (early != -1) $display("FAIL sweep_ready_early: ready rose after %0d clocks, required 2048", early);
    else n_pass++;
    n_checks++;
    if (bad_out) $display("FAIL sweep_outputs: got nonzero data_out/data_oe during sweep, expected 0");
    else n_pass++;
    n_checks++;
    if ({d1_ready, d2_ready} !== 2'b11) $display("FAIL sweep_ready_end: got %b expected 11", {d1_ready, d2_ready});
    else n_pass++;
    in_run = 1'b1;
  endtask

  task automatic test_fill();
    do_cycle(16'h07FF, 1'b1, 8'h00);
    n_checks++;
    if (d1_out !== 8'h00 || d1_oe !== 1'b1) $display("FAIL fill_07ff_l1: got %h/%b expected 00/1", d1_out, d1_oe);
    else n_pass++;
    do_cycle(16'h0000, 1'b1, 8'h00);
    n_checks++;
    if (d2_out !== 8'hC3 || d2_oe !== 1'b1) $display("FAIL fill_07ff_l2: got %h/%b expected c3/1", d2_out, d2_oe);
    else n_pass++;
  endtask

  task automatic test_mirror();
    do_cycle(16'h0821, 1'b0, 8'h31);
    n_checks++;
    if (d1_oe !== 1'b0 || d1_out !== 8'h00) $display("FAIL write_no_data: got %h/%b expected 00/0", d1_out, d1_oe);
    else n_pass++;
    do_cycle(16'h0822, 1'b0, 8'h14);
    do_cycle(16'h0021, 1'b1, 8'h00);
    n_checks++;
    if (d1_out !== 8'h31 || d1_oe !== 1'b1) $display("FAIL mirror_0021: got %h/%b expected 31/1", d1_out, d1_oe);
    else n_pass++;
    do_cycle(16'h1022, 1'b1, 8'h00);
    n_checks++;
    if (d1_out !== 8'h14 || d1_oe !== 1'b1) $display("FAIL mirror_1022: got %h/%b expected 14/1", d1_out, d1_oe);
    else n_pass++;
    do_cycle(16'h1821, 1'b1, 8'h00);
    n_checks++;
    if (d1_out !== 8'h31 || d1_oe !== 1'b1) $display("FAIL mirror_1821: got %h/%b expected 31/1", d1_out, d1_oe);
    else n_pass++;
  endtask

  task automatic test_unselected();
    do_cycle(16'h2000, 1'b1, 8'h00);
    n_checks++;
    if (d1_sel !== 1'b0 || d1_oe !== 1'b0 || d1_out !== 8'h00)
      $display("FAIL unsel_read: got sel=%b oe=%b data=%h expected 0/0/00", d1_sel, d1_oe, d1_out);
    else n_pass++;
    do_cycle(16'h2000, 1'b0, 8'hAA);
    do_cycle(16'h0000, 1'b1, 8'h00);
    n_checks++;
    if (d1_out !== 8'h00 || d1_oe !== 1'b1) $display("FAIL unsel_write_0000: got %h/%b expected 00/1", d1_out, d1_oe);
    else n_pass++;
  endtask

  task automatic test_latency2();
    do_cycle(16'h0100, 1'b0, 8'h5A);
    do_cycle(16'h0100, 1'b1, 8'h00);
    n_checks++;
    if (d2_oe !== 1'b0) $display("FAIL lat2_one_clock: got oe=%b expected 0", d2_oe);
    else n_pass++;
    do_cycle(16'h0101, 1'b1, 8'h00);
    n_checks++;
    if (d2_out !== 8'h5A || d2_oe !== 1'b1) $display("FAIL lat2_0100: got %h/%b expected 5a/1", d2_out, d2_oe);
    else n_pass++;
    do_cycle(16'h4000, 1'b1, 8'h00);
    n_checks++;
    if (d2_out !== 8'hC3 || d2_oe !== 1'b1) $display("FAIL lat2_stream_0101: got %h/%b expected c3/1", d2_out, d2_oe);
    else n_pass++;
    do_cycle(16'h4000, 1'b1, 8'h00);
    n_checks++;
    if (d2_out !== 8'h00 || d2_oe !== 1'b0) $display("FAIL lat2_idle: got %h/%b expected 00/0", d2_out, d2_oe);
    else n_pass++;
  endtask

  task automatic test_random(input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = 16'(($urandom_range(0, 5) << 11) | $urandom_range(0, 15));
      do_cycle(a, 1'($urandom_range(0, 1)), 8'($urandom));
      n_checks++;
      if (d1_sel !== (a < 16'h2000)) $display("FAIL rand_sel[%0d]: addr %h got %b expected %b", i, a, d1_sel, a < 16'h2000);
      else n_pass++;
      n_checks++;
      if (d1_out !== e1_data || d1_oe !== e1_oe)
        $display("FAIL rand_l1[%0d]: addr %h got %h/%b expected %h/%b", i, a, d1_out, d1_oe, e1_data, e1_oe);
      else n_pass++;
      n_checks++;
      if (d2_out !== e2_data || d2_oe !== e2_oe)
        $display("FAIL rand_l2[%0d]: addr %h got %h/%b expected %h/%b", i, a, d2_out, d2_oe, e2_data, e2_oe);
      else n_pass++;
    end
  endtask

`ifdef MIRRORED_BUS_RAM_WP_EN
  task automatic test_wp();
    logic [7:0] old;
    old = m1[16];
    wp = 1'b1;
    do_cycle(16'h0010, 1'b0, 8'h77);
    do_cycle(16'h0010, 1'b1, 8'h00);
    n_checks++;
    if (d1_out !== old || wpv1 !== 1'b1) $display("FAIL wp_block: got %h viol=%b expected %h viol=1", d1_out, wpv1, old);
    else n_pass++;
    wp = 1'b0;
    do_cycle(16'h0010, 1'b0, 8'h77);
    do_cycle(16'h0010, 1'b1, 8'h00);
    n_checks++;
    if (d1_out !== 8'h77 || wpv1 !== 1'b1) $display("FAIL wp_release: got %h viol=%b expected 77 viol=1", d1_out, wpv1);
    else n_pass++;
  endtask
`endif

  task automatic test_mid_reset();
    int early;
    do_cycle(16'h0005, 1'b0, 8'h3C);
    do_cycle(16'h0005, 1'b1, 8'h00);
    n_checks++;
    if (d1_out !== 8'h3C || d1_oe !== 1'b1) $display("FAIL pre_reset_read: got %h/%b expected 3c/1", d1_out, d1_oe);
    else n_pass++;
    #2;
    apply_reset();
    #1;
    n_checks++;
    if ({d1_ready, d2_ready, d1_oe, d2_oe, d1_out, d2_out} !== 20'h0)
      $display("FAIL reset_mid_read: got %h expected 0", {d1_ready, d2_ready, d1_oe, d2_oe, d1_out, d2_out});
    else n_pass++;
`ifdef MIRRORED_BUS_RAM_WP_EN
    n_checks++;
    if (wpv1 !== 1'b0) $display("FAIL wp_cleared: got %b expected 0", wpv1);
    else n_pass++;
`endif
    @(negedge clock);
    nreset = 1'b1;
    for (int i = 0; i < 1000; i++) do_cycle(16'h0000, 1'b1, 8'h00);
    #2;
    nreset = 1'b0;
    #1;
    n_checks++;
    if ({d1_ready, d2_ready, d1_out, d2_out} !== 18'h0)
      $display("FAIL reset_mid_sweep: got %h expected 0", {d1_ready, d2_ready, d1_out, d2_out});
    else n_pass++;
    @(negedge clock);
    nreset = 1'b1;
    early = -1;
    for (int i = 1; i <= 2048; i++) begin
      do_cycle(16'h0005, 1'b0, 8'h99);
      if (i < 2048 && {d1_ready, d2_ready} !== 2'b00 && early < 0) early = i;
    end
    n_checks++;
    if (early != -1) $display("FAIL resweep_early: ready rose after %0d clocks, required 2048", early);
    else n_pass++;
    n_checks++;
    if ({d1_ready, d2_ready} !== 2'b11) $display("FAIL resweep_end: got %b expected 11", {d1_ready, d2_ready});
    else n_pass++;
    in_run = 1'b1;
    do_cycle(16'h0805, 1'b1, 8'h00);
    n_checks++;
    if (d1_out !== FILL1 || d1_oe !== 1'b1) $display("FAIL resweep_0005: got %h/%b expected 00/1", d1_out, d1_oe);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_mirror();
    test_unselected();
    test_latency2();
    test_random(300);
`ifdef MIRRORED_BUS_RAM_WP_EN
    test_wp();
`endif
    test_mid_reset();
    test_random(200);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
